// File: rtl/regfile_scan_reader.sv
// rtl/regfile_scan_reader.sv - walks a register-file address range and streams each value out with a valid/ready handshake
module regfile_scan_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [DATA_W-1:0] rd_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   end_addr_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                out_last_q;
  logic                done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      end_addr_q <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q      <= first_addr;
            end_addr_q <= last_addr;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          // Captured word stays frozen through SEND, so register-file writes during a stall are invisible
          out_data_q <= rd_value;
          out_addr_q <= ptr_q;
          out_last_q <= (ptr_q == end_addr_q);
          state_q    <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              ptr_q   <= ptr_q + 1'b1;
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_address = (state_q == IDLE) ? '0 : ptr_q;
  assign out_valid  = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_last   = out_last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// tb/tb_regfile_scan_reader.sv - directed scoreboard bench for regfile_scan_reader
module tb_regfile_scan_reader;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] rd_value;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  logic [DW-1:0] regs [NREG];
  assign rd_value = regs[rd_address];

  regfile_scan_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_address(rd_address), .rd_value(rd_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  word_t sb[$];
  int checks = 0;
  int errors = 0;
  int words_seen = 0;
  int dones_seen = 0;
  int exp_words = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare any presented word against the scoreboard head, then advance one clock
  task automatic step();
    word_t w;
    logic  done_exp;
    done_exp = 1'b0;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", out_valid, 0);
      end else begin
        w = sb[0];
        chk("out_addr", out_addr, w.a);
        chk("out_data", out_data, w.d);
        chk("out_last", out_last, w.l);
        chk("rd_address_send", rd_address, w.a);
        if (out_ready) begin
          void'(sb.pop_front());
          words_seen++;
          done_exp = w.l;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("done", done, done_exp);
    if (done) dones_seen++;
    if (!busy) chk("rd_address_idle", rd_address, 0);
  endtask

  task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
    logic [AW-1:0] a;
    logic [AW-1:0] span;
    span = l - f;
    exp_words = int'(span) + 1;
    for (int i = 0; i < exp_words; i++) begin
      a = f + AW'(i);
      sb.push_back({a, regs[a], a == l});
    end
  endtask

  task automatic begin_scan(input logic [AW-1:0] f, input logic [AW-1:0] l);
    push_range(f, l);
    words_seen = 0;
    dones_seen = 0;
    first_addr = f;
    last_addr = l;
    start = 1'b1;
    step();
    start = 1'b0;
    first_addr = ~f;
    last_addr = ~l;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_scan(input int poke, input logic [AW-1:0] stall_a, input bit do_stall);
    bit stalled;
    stalled = 1'b0;
    for (int c = 0; c < 300 && dones_seen == 0; c++) begin
      if (c == poke) begin
        start = 1'b1;
        first_addr = first_addr + 3;
        last_addr = first_addr;
      end else begin
        start = 1'b0;
      end
      if (do_stall && !stalled && out_valid && out_addr == stall_a) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          if (k == 2) regs[stall_a] = 32'hDEAD;
          step();
          chk("stall_rd_address", rd_address, stall_a);
          chk("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
      end
      step();
    end
    start = 1'b0;
    chk("word_count", words_seen, exp_words);
    chk("done_pulses", dones_seen, 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    logic [6:0] vpat;
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    regs[1] = 32'h11;
    regs[2] = 32'h22;
    regs[3] = 32'h33;

    step();
    step();
    chk("rst_rd_address", rd_address, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // out_ready while idle does nothing
    out_ready = 1'b1;
    step();
    step();
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);

    // Basic scan with exact cycle pattern
    begin_scan(5'd1, 5'd3);
    vpat = 7'b0101010;
    chk("lat_valid_0", out_valid, vpat[6]);
    for (int k = 1; k < 7; k++) begin
      step();
      chk("lat_valid", out_valid, vpat[6-k]);
    end
    chk("basic_done_pulses", dones_seen, 1);
    chk("basic_words", words_seen, 3);
    step();

    // Backpressure with register rewrite during the stall
    begin_scan(5'd1, 5'd3);
    wait_scan(-1, 5'd2, 1'b1);
    step();

    // Wrap-around
    begin_scan(5'd30, 5'd1);
    wait_scan(-1, 5'd0, 1'b0);

    // Full scan, then start accepted in the done cycle
    begin_scan(5'd5, 5'd4);
    wait_scan(-1, 5'd0, 1'b0);
    chk("done_cycle", done, 1);
    begin_scan(5'd20, 5'd22);
    wait_scan(-1, 5'd0, 1'b0);
    step();

    // start pulsed while busy must be ignored
    begin_scan(5'd10, 5'd14);
    wait_scan(3, 5'd0, 1'b0);
    step();

    // Reset mid-scan
    begin_scan(5'd0, 5'd7);
    for (int c = 0; c < 50 && words_seen < 2; c++) step();
    chk("pre_reset_words", words_seen, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    sb.delete();
    step();
    chk("post_rst_no_done", dones_seen, 0);
    begin_scan(5'd9, 5'd9);
    wait_scan(-1, 5'd0, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_scan_reader.md
REGFILE_SCAN_READER -- requirements
Module: regfile_scan_reader

Interface
REQ-001 Parameter ADDR_W, default 5: register address width; the scan covers 2^ADDR_W registers.
REQ-002 Parameter DATA_W, default 32: register data width.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a scan; sampled only in IDLE.
REQ-006 first_addr  input  ADDR_W  first register of the scan; sampled with start.
REQ-007 last_addr  input  ADDR_W  last register of the scan, inclusive; sampled with start.
REQ-008 rd_address  output  ADDR_W  address driven to the register-file read port.
REQ-009 rd_value  input  DATA_W  asynchronous read data returned for rd_address.
REQ-010 out_valid  output  1  out_data/out_addr/out_last hold a word.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_data  output  DATA_W  captured register value.
REQ-013 out_addr  output  ADDR_W  register address of out_data.
REQ-014 out_last  output  1  the current word is the final word of the scan.
REQ-015 busy  output  1  a scan is in progress (state not IDLE).
REQ-016 done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, FETCH and SEND.
REQ-018 In IDLE, a cycle with start=1 SHALL latch first_addr into ptr and last_addr into end_addr, then enter FETCH.
REQ-019 start SHALL be ignored in FETCH and SEND, and the latched range SHALL NOT change mid-scan.
REQ-020 rd_address SHALL equal ptr in FETCH and SEND, and 0 in IDLE.
REQ-021 In FETCH, the block SHALL capture rd_value into out_data at the clock edge, set out_addr=ptr, set out_last=(ptr==end_addr), and enter SEND.
REQ-022 In SEND, out_valid SHALL be 1; out_valid SHALL be 0 in every other state.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_addr and out_last SHALL hold stable, even if the register-file contents change.
REQ-024 Handshake rule: a word transfers on a cycle with out_valid=1 and out_ready=1.
REQ-025 On a transfer with out_last=0, ptr SHALL increment modulo 2^ADDR_W and the FSM SHALL return to FETCH.
REQ-026 On a transfer with out_last=1, the FSM SHALL go to IDLE and done SHALL be 1 in the following cycle only.
REQ-027 Latency, with out_ready held at 1:
  - start seen at edge N;
  - first out_valid in the cycle after edge N+1;
  - one word every 2 cycles after that;
  - done in the cycle after the last transfer.
REQ-028 Word count SHALL be ((last_addr - first_addr) mod 2^ADDR_W) + 1.
REQ-029 Range rules:
  - first_addr == last_addr gives exactly 1 word;
  - first_addr > last_addr wraps from 2^ADDR_W-1 to 0;
  - first_addr = last_addr+1 (mod 2^ADDR_W) gives all 2^ADDR_W words.
REQ-030 Address 0 SHALL be scanned like any other address; its value is whatever the read port returns.
REQ-031 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-032 start asserted in the same cycle that done=1 SHALL be accepted, because the FSM is already in IDLE.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE from any state, abandoning any scan in progress without a done pulse.
REQ-034 Reset values:
  - rd_address=0, out_valid=0, out_data=0, out_addr=0, out_last=0;
  - busy=0, done=0;
  - ptr=0, end_addr=0.
REQ-035 reset SHALL take priority over start and over any handshake in the same cycle.

Verification
REQ-036 Regfile preloaded with x1=0x11, x2=0x22, x3=0x33; start with first=1, last=3; out_ready=1 -> words (1,0x11), (2,0x22), (3,0x33,last=1), 2 cycles apart; done pulses once.
REQ-037 Wrap: first=30, last=1 -> out_addr sequence 30, 31, 0, 1; out_last=1 only on address 1.
REQ-038 Backpressure: out_ready=0 for 5 cycles on word 2, and x2 rewritten to 0xDEAD during the stall -> out_data holds 0x22 until accepted; rd_address stays 2.
REQ-039 Full scan: first=5, last=4 -> 32 words, addresses 5..31 then 0..4; done pulses once.
REQ-040 Reset mid-scan after 2 words (first=0, last=7) -> next cycle busy=0, out_valid=0, no done; a new start with first=last=9 yields one word, address 9, with out_last=1.
REQ-041 start pulsed while busy -> ignored; the scan completes with the original range and word count.
